// File: rtl/button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pkg
//  Board-level constants for the DE0 push-button debouncer and the defaults
//  derived from them.
//   CLK_HZ       system clock frequency
//   DEBOUNCE_MS  time a new button level must persist before it is accepted
//   BUTTON_IDLE  level of an un-pressed DE0 key (keys are active-low)
//  The sample tick is 1 ms, so the prescaler divisor is CLK_HZ/1000 and the
//  number of stable ticks equals DEBOUNCE_MS.
// -----------------------------------------------------------------------------
package button_debounce_pkg;

  localparam int   CLK_HZ      = 50_000_000;
  localparam int   DEBOUNCE_MS = 20;
  localparam logic BUTTON_IDLE = 1'b1;

  // One sample tick per millisecond.
  localparam int TICK_DIV_DEFAULT     = CLK_HZ / 1000;
  localparam int STABLE_TICKS_DEFAULT = DEBOUNCE_MS;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : button_debounce_pkg

// File: rtl/button_debounce_chan.sv
// -----------------------------------------------------------------------------
// button_debounce_chan
//  One debounced button channel: a two-flop synchroniser followed by a
//  persistence counter. A new synchronised level is accepted only after it
//  has differed from the current stable level on STABLE_TICKS consecutive
//  sample ticks with no agreeing cycle in between.
// Ports
//  clk      in  1  system clock
//  reset_n  in  1  asynchronous active-low reset
//  tick     in  1  shared sample strobe from the top-level prescaler
//  raw      in  1  raw asynchronous button pin
//  stable   out 1  debounced level
//  fall     out 1  one-cycle strobe, stable went 1->0
//  rise     out 1  one-cycle strobe, stable went 0->1
// -----------------------------------------------------------------------------
module button_debounce_chan
  import button_debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter logic RESET_BIT    = BUTTON_IDLE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic fall,
  output logic rise
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_fall;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // Next-state values for the counter and the stable/strobe registers.
  logic          w_differ;
  logic          w_commit;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_differ  = (r_s2 != r_stable);
    w_commit  = 1'b0;
    w_cnt_nxt = r_cnt;
    if (!w_differ) begin
      // Any agreeing cycle cancels a pending change.
      w_cnt_nxt = '0;
    end else if (tick) begin
      if (r_cnt == CNT_LAST) begin
        w_commit  = 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // Synchroniser stages are plain flop-to-flop with nothing in between.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= RESET_BIT;
      r_s2     <= RESET_BIT;
      r_stable <= RESET_BIT;
      r_fall   <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1   <= raw;
      r_s2   <= r_s1;
      r_cnt  <= w_cnt_nxt;
      // Strobes are registered alongside stable so they mark exactly the
      // first cycle the new level is visible.
      r_fall <= w_commit & ~r_s2;
      r_rise <= w_commit &  r_s2;
      if (w_commit) begin
        r_stable <= r_s2;
      end
    end
  end

  assign stable = r_stable;
  assign fall   = r_fall;
  assign rise   = r_rise;

endmodule : button_debounce_chan

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//  Synchronises and debounces the raw DE0 push-button pins and drives the
//  button PIO input port, so the PIO edge detector sees one clean transition
//  per physical press or release. Also provides one-cycle press/release
//  strobes for local fabric logic.
// Ports
//  clk         in  1      system clock (single domain)
//  reset_n     in  1      asynchronous active-low reset
//  btn_in      in  WIDTH  raw asynchronous button pins
//  btn_stable  out WIDTH  debounced level, to the PIO in_port
//  btn_fall    out WIDTH  one-cycle strobe per bit, stable 1->0 (press)
//  btn_rise    out WIDTH  one-cycle strobe per bit, stable 0->1 (release)
// -----------------------------------------------------------------------------
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int               WIDTH        = 3,
  parameter int               TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int               STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_LEVEL  = {WIDTH{BUTTON_IDLE}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_stable,
  output logic [WIDTH-1:0] btn_fall,
  output logic [WIDTH-1:0] btn_rise
);

  logic w_tick;

  // Free-running prescaler shared by all channels; its wrap is the only
  // wrap-around in the design. A divisor of one degenerates to a constant
  // tick with no counter at all.
  generate
    if (TICK_DIV == 1) begin : g_tick_const
      assign w_tick = 1'b1;
    end else begin : g_prescaler
      localparam int            PW     = cnt_width(TICK_DIV);
      localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

      logic [PW-1:0] r_pcnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_pcnt <= '0;
        end else if (r_pcnt == P_LAST) begin
          r_pcnt <= '0;
        end else begin
          r_pcnt <= r_pcnt + PW'(1);
        end
      end

      assign w_tick = (r_pcnt == P_LAST);
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      button_debounce_chan #(
        .STABLE_TICKS (STABLE_TICKS),
        .RESET_BIT    (RESET_LEVEL[i])
      ) u_chan (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick),
        .raw     (btn_in[i]),
        .stable  (btn_stable[i]),
        .fall    (btn_fall[i]),
        .rise    (btn_rise[i])
      );
    end
  endgenerate

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//  Directed bench for button_debounce with WIDTH=3, TICK_DIV=4,
//  STABLE_TICKS=3, RESET_LEVEL=3'b111. Each stimulus that should cause a
//  commit pushes the expected {stable, fall, rise} word and its allowed cycle
//  window; a monitor pops and compares whenever the DUT shows an event
//  (stable change or any strobe).
// -----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int W  = 3;
  localparam int EW = 3 * W;
  // Edge-to-commit window: 2 + [(3-1)*4+1 .. 3*4].
  localparam int LAT_MIN = 11;
  localparam int LAT_MAX = 14;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] btn_in  = 3'b111;
  logic [W-1:0] btn_stable;
  logic [W-1:0] btn_fall;
  logic [W-1:0] btn_rise;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];
  int            lo_q[$];
  int            hi_q[$];

  logic         mon_en      = 1'b0;
  logic [W-1:0] prev_stable = 3'b111;

  button_debounce #(
    .WIDTH        (W),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .RESET_LEVEL  (3'b111)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_in     (btn_in),
    .btn_stable (btn_stable),
    .btn_fall   (btn_fall),
    .btn_rise   (btn_rise)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if ((btn_stable != prev_stable) || (btn_fall != '0) || (btn_rise != '0)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got stable=%b fall=%b rise=%b expected no event (cycle %0d)",
                   btn_stable, btn_fall, btn_rise, cyc);
        end else begin
          logic [EW-1:0] e;
          int lo;
          int hi;
          e  = exp_q.pop_front();
          lo = lo_q.pop_front();
          hi = hi_q.pop_front();
          check("event_value", 32'({btn_stable, btn_fall, btn_rise}), 32'(e));
          check("event_in_window", 32'((cyc >= lo) && (cyc <= hi)), 32'd1);
        end
      end
      prev_stable = btn_stable;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drive btn_in just after a rising edge; returns the cycle of that edge.
  task automatic drive(input logic [W-1:0] v, output int edge_cyc);
    @(posedge clk);
    #1;
    btn_in   = v;
    edge_cyc = cyc;
  endtask

  task automatic expect_event(input logic [W-1:0] st, input logic [W-1:0] f,
                              input logic [W-1:0] r, input int edge_cyc);
    exp_q.push_back({st, f, r});
    lo_q.push_back(edge_cyc + LAT_MIN);
    hi_q.push_back(edge_cyc + LAT_MAX);
  endtask

  // Wait until the scoreboard is drained, then a few extra cycles so a
  // lingering strobe would be flagged as an unexpected event.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending events expected 0", name, exp_q.size());
      exp_q.delete();
      lo_q.delete();
      hi_q.delete();
    end
    wait_cycles(6);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e;

    // 1. reset with idle buttons, then hold 100 cycles quietly
    #2 reset_n = 1'b0;
    mon_en = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    check("reset_stable", 32'(btn_stable), 32'h7);
    check("reset_fall", 32'(btn_fall), 32'h0);
    check("reset_rise", 32'(btn_rise), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_cycles(100);
    @(negedge clk);
    check("idle_hold_stable", 32'(btn_stable), 32'h7);

    // 3. bounce on bit 0: toggles every 3 cycles for 60 cycles, settles high
    for (int k = 0; k < 20; k++) begin
      drive((k % 2 == 0) ? 3'b110 : 3'b111, e);
      wait_cycles(2);
    end
    drive(3'b111, e);
    wait_cycles(30);
    @(negedge clk);
    check("bounce_stable", 32'(btn_stable), 32'h7);

    // 2. press bit 0
    drive(3'b110, e);
    expect_event(3'b110, 3'b001, 3'b000, e);
    drain("press0");

    // 4. release bit 0
    drive(3'b111, e);
    expect_event(3'b111, 3'b000, 3'b001, e);
    drain("release0");

    // 5. bits 1 and 2 pressed together, then released together
    drive(3'b001, e);
    expect_event(3'b001, 3'b110, 3'b000, e);
    drain("press12");
    drive(3'b111, e);
    expect_event(3'b111, 3'b000, 3'b110, e);
    drain("release12");

    // 6. reset part-way through a pending press
    drive(3'b110, e);
    wait_cycles(8);
    #1 reset_n = 1'b0;
    wait_cycles(2);
    @(negedge clk);
    check("midreset_stable", 32'(btn_stable), 32'h7);
    check("midreset_fall", 32'(btn_fall), 32'h0);
    check("midreset_rise", 32'(btn_rise), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    e = cyc;
    expect_event(3'b110, 3'b001, 3'b000, e);
    drain("press_after_reset");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule : tb_button_debounce
